// File: rtl/nnp_pkg.sv
// Shared definitions for the instruction fetch front end.
//   PC_W / INSTR_W        : default address and instruction word widths
//   OPCODE_MSB/OPCODE_LSB : opcode field position inside an instruction word
//   fetch_state_t         : fetch FSM state encoding
//   STEP_HALT             : pc_step value meaning illegal/unknown opcode
package nnp_pkg;

    localparam int PC_W       = 8;
    localparam int INSTR_W    = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 24;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [7:0] STEP_HALT = 8'd0;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one instruction memory read at a time,
// presents the returned word to decode and advances the PC by the step
// decode hands back on accept. A zero step parks the unit in HALT.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   imem_req/imem_addr    : registered read request and word address
//   imem_gnt              : memory accepts the request (req & gnt)
//   imem_rvalid/rdata     : read response, at least one cycle after grant
//   instr_valid/out/pc    : instruction presented to decode
//   instr_accept/pc_step  : decode handshake and PC increment
//   flush/flush_pc        : redirect, highest priority in every state
//   halted                : unit parked after an illegal opcode
//
// state | meaning
// ------+---------------------------------------------------------------
// FETCH | request (pc) driven, waiting for grant (or for a stale response
//       | to drain when drop_pending is set)
// WAIT  | request granted, waiting for read data
// HOLD  | instruction presented, waiting for decode to accept
// HALT  | illegal opcode seen, idle until flush or reset
module instr_fetch_unit
    import nnp_pkg::*;
#(
    parameter int                       PC_W     = nnp_pkg::PC_W,
    parameter int                       INSTR_W  = nnp_pkg::INSTR_W,
    parameter logic [nnp_pkg::PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_accept,
    input  logic [7:0]         pc_step,
    input  logic               flush,
    input  logic [PC_W-1:0]    flush_pc,
    output logic               halted
);

    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               req_q, req_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] out_q, out_d;
    logic [PC_W-1:0]    ipc_q, ipc_d;
    logic               halted_q, halted_d;
    logic               drop_q, drop_d;
    logic               handshake;

    assign handshake = req_q & imem_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            valid_q  <= 1'b0;
            out_q    <= '0;
            ipc_q    <= '0;
            halted_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            out_q    <= out_d;
            ipc_q    <= ipc_d;
            halted_q <= halted_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        out_d    = out_q;
        ipc_d    = ipc_q;
        halted_d = halted_q;
        drop_d   = drop_q;

        // A response owed to a request that was flushed is swallowed here,
        // whatever state the FSM has moved on to.
        if (drop_q && imem_rvalid) begin
            drop_d = 1'b0;
        end

        if (flush) begin
            state_d  = FETCH;
            pc_d     = flush_pc;
            valid_d  = 1'b0;
            halted_d = 1'b0;
            // A request is still in flight: remember to discard its data.
            // If the data arrives in the flush cycle it is simply not latched.
            if ((state_q == FETCH) && handshake) begin
                drop_d = 1'b1;
            end
            if ((state_q == WAIT) && !imem_rvalid) begin
                drop_d = 1'b1;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (handshake) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid && !drop_q) begin
                        valid_d = 1'b1;
                        out_d   = imem_rdata;
                        ipc_d   = pc_q;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (instr_accept) begin
                        valid_d = 1'b0;
                        if (pc_step == STEP_HALT) begin
                            halted_d = 1'b1;
                            state_d  = HALT;
                        end else begin
                            pc_d    = pc_q + PC_W'(pc_step);
                            state_d = FETCH;
                        end
                    end
                end
                HALT: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end

        // Request is registered from the next state so it drops the cycle
        // after a grant and stays low until any stale response has drained.
        req_d = (state_d == FETCH) && !drop_d;
        if (state_d == FETCH) begin
            addr_d = pc_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr_out   = out_q;
    assign instr_pc    = ipc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [7:0]  instr_pc;
    logic        instr_accept;
    logic [7:0]  pc_step;
    logic        flush;
    logic [7:0]  flush_pc;
    logic        halted;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .instr_accept (instr_accept),
        .pc_step      (pc_step),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expects a request for exp_addr to be driven on entry; grants it,
    // returns data one cycle later and stalls decode for three cycles
    task automatic do_fetch(input string tag, input logic [7:0] exp_addr, input logic [31:0] data);
        chk({tag, "_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_addr"}, 32'(imem_addr), 32'(exp_addr));
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk({tag, "_req_drop"}, 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_out"}, instr_out, data);
        chk({tag, "_pc"}, 32'(instr_pc), 32'(exp_addr));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk({tag, "_stall_out"}, instr_out, data);
            chk({tag, "_stall_valid"}, 32'(instr_valid), 32'd1);
        end
    endtask

    task automatic do_accept(input string tag, input logic [7:0] step);
        instr_accept = 1'b1;
        pc_step      = step;
        tick();
        instr_accept = 1'b0;
        pc_step      = 8'd0;
        chk({tag, "_valid_clr"}, 32'(instr_valid), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        instr_accept = 1'b0;
        pc_step      = 8'd0;
        flush        = 1'b0;
        flush_pc     = 8'h0;

        tick();
        tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'h00);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_out", instr_out, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);

        rst_n = 1'b1;
        chk("rel_req_low", 32'(imem_req), 32'd0);
        tick();

        // sequential fetch with steps 2, 3, 1
        do_fetch("f0", 8'h00, 32'h01000000);
        do_accept("a0", 8'd2);
        do_fetch("f1", 8'h02, 32'h02000011);
        do_accept("a1", 8'd3);
        do_fetch("f2", 8'h05, 32'h03000022);
        do_accept("a2", 8'd1);
        do_fetch("f3", 8'h06, 32'h04000033);

        // flush from HOLD to 0xFE, then step 3 wraps to 0x01
        flush = 1'b1; flush_pc = 8'hFE;
        tick();
        flush = 1'b0;
        chk("fl_hold_valid", 32'(instr_valid), 32'd0);
        do_fetch("f4", 8'hFE, 32'h05000044);
        do_accept("a4", 8'd3);
        do_fetch("f5", 8'h01, 32'h06000055);

        // flush and accept together: flush wins
        instr_accept = 1'b1; pc_step = 8'd2;
        flush = 1'b1; flush_pc = 8'h20;
        tick();
        instr_accept = 1'b0; pc_step = 8'd0; flush = 1'b0;
        chk("fa_valid", 32'(instr_valid), 32'd0);
        chk("fa_addr", 32'(imem_addr), 32'h20);

        // flush in FETCH before grant retargets the address
        flush = 1'b1; flush_pc = 8'h30;
        tick();
        flush = 1'b0;
        do_fetch("f6", 8'h30, 32'h07000066);

        // step 0 halts
        do_accept("a6", 8'd0);
        chk("halt_set", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
        end
        flush = 1'b1; flush_pc = 8'h40;
        tick();
        flush = 1'b0;
        chk("unhalt", 32'(halted), 32'd0);

        // flush in WAIT, stale data two cycles later is dropped
        chk("w_req", 32'(imem_req), 32'd1);
        chk("w_addr", 32'(imem_addr), 32'h40);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        flush = 1'b1; flush_pc = 8'h10;
        tick();
        flush = 1'b0;
        chk("w_req_blocked0", 32'(imem_req), 32'd0);
        tick();
        chk("w_req_blocked1", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        tick();
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        chk("w_stale_valid", 32'(instr_valid), 32'd0);
        do_fetch("f7", 8'h10, 32'h08000077);

        // async reset mid-HOLD
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(instr_valid), 32'd0);
        chk("ar_addr", 32'(imem_addr), 32'h00);
        chk("ar_pc", 32'(instr_pc), 32'h00);
        chk("ar_req", 32'(imem_req), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_rel_req", 32'(imem_req), 32'd1);
        chk("ar_rel_addr", 32'(imem_addr), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
